// File: rtl/median_line_delay.sv
// Circular-buffer line delay: re-emits each accepted pixel exactly L accepted
// samples later, with a valid flag that stays low while the first line primes.
module median_line_delay #(
    parameter int N       = 8,
    parameter int MAX_LEN = 1024,
    parameter int AW      = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ce,
    input  logic [AW:0]   line_len,
    input  logic [N-1:0]  d,
    output logic [N-1:0]  q,
    output logic          valid
);

    typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

    localparam logic [AW:0] MAX_LEN_W = (AW+1)'(MAX_LEN);

    state_t        state_reg;
    logic [AW:0]   len_reg;
    logic [AW:0]   cnt_reg;
    logic [AW-1:0] ptr_reg;
    logic [N-1:0]  q_reg;
    logic          valid_reg;

    logic [N-1:0]  mem [MAX_LEN];

    logic [AW:0]   eff_len;
    logic [AW:0]   len_m1;
    logic          wrap;
    logic [AW-1:0] ptr_adv;

    always_comb begin
        // Zero or oversize requests fall back to the full RAM depth.
        eff_len = (line_len == '0 || line_len > MAX_LEN_W) ? MAX_LEN_W : line_len;
        len_m1  = len_reg - (AW+1)'(1);
        wrap    = ({1'b0, ptr_reg} == len_m1);
        ptr_adv = wrap ? '0 : ptr_reg + AW'(1);
    end

    // Write port; the registered read in the control block sees the old word.
    always_ff @(posedge clk) begin
        if (ce && !rst) begin
            mem[ptr_reg] <= d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            len_reg   <= '0;
            cnt_reg   <= '0;
            ptr_reg   <= '0;
            q_reg     <= '0;
            valid_reg <= 1'b0;
        end else if (ce) begin
            case (state_reg)
                IDLE: begin
                    len_reg   <= eff_len;
                    cnt_reg   <= (AW+1)'(1);
                    ptr_reg   <= (eff_len == (AW+1)'(1)) ? '0 : AW'(1);
                    state_reg <= (eff_len == (AW+1)'(1)) ? RUN : FILL;
                    q_reg     <= '0;
                    valid_reg <= 1'b0;
                end
                FILL: begin
                    cnt_reg   <= cnt_reg + (AW+1)'(1);
                    ptr_reg   <= ptr_adv;
                    q_reg     <= '0;
                    valid_reg <= 1'b0;
                    if (cnt_reg == len_m1) begin
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    q_reg     <= mem[ptr_reg];
                    valid_reg <= 1'b1;
                    ptr_reg   <= ptr_adv;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign q     = q_reg;
    assign valid = valid_reg;

endmodule

// File: tb/tb_median_line_delay.sv
// Scoreboard bench for median_line_delay (MAX_LEN = 16): a FIFO reference model
// pushes the expected {valid,q} per cycle, popped and compared after the edge.
module tb_median_line_delay;

    localparam int N       = 8;
    localparam int MAX_LEN = 16;
    localparam int AW      = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ce = 1'b0;
    logic [AW:0]   line_len = '0;
    logic [N-1:0]  d = '0;
    logic [N-1:0]  q;
    logic          valid;

    median_line_delay #(.N(N), .MAX_LEN(MAX_LEN), .AW(AW)) dut (
        .clk      (clk),
        .rst      (rst),
        .ce       (ce),
        .line_len (line_len),
        .d        (d),
        .q        (q),
        .valid    (valid)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [N:0]   exp_q [$];
    logic [N-1:0] hist [$];
    logic [N:0]   last_exp = '0;
    int           k = 0;
    int           m_len = 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic int eff_len(input logic [AW:0] ll);
        if (ll == 0 || int'(ll) > MAX_LEN) return MAX_LEN;
        return int'(ll);
    endfunction

    task automatic cycle(input string tag, input logic r, input logic c,
                         input logic [N-1:0] dv, input logic [AW:0] ll);
        logic [N:0] e;
        @(negedge clk);
        rst = r; ce = c; d = dv; line_len = ll;
        if (r) begin
            hist.delete();
            k = 0;
            last_exp = '0;
        end else if (c) begin
            if (k == 0) m_len = eff_len(ll);
            k++;
            hist.push_back(dv);
            if (hist.size() > m_len) last_exp = {1'b1, hist.pop_front()};
            else last_exp = '0;
        end
        exp_q.push_back(last_exp);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check_eq({tag, "_q"}, 32'(q), 32'(e[N-1:0]));
        check_eq({tag, "_valid"}, 32'(valid), 32'(e[N]));
        $display("%s rst=%0b ce=%0b d=0x%02h -> q=0x%02h valid=%0b", tag, r, c, dv, q, valid);
    endtask

    task automatic do_reset();
        cycle("reset", 1'b1, 1'b0, 8'h00, '0);
        cycle("reset", 1'b1, 1'b1, 8'hFF, '0);
    endtask

    initial begin
        do_reset();
        check_eq("reset_state_q", 32'(q), 32'h0);
        check_eq("reset_state_valid", 32'(valid), 32'h0);

        // Ramp with L = 4: valid after sample 5, q = 16 after sample 20.
        for (int i = 1; i <= 20; i++) cycle("ramp", 1'b0, 1'b1, 8'(i), 5'd4);
        check_eq("ramp_last_q", 32'(q), 32'd16);

        // L = 1 behaves as a single registered delay.
        do_reset();
        cycle("len1", 1'b0, 1'b1, 8'hA5, 5'd1);
        cycle("len1", 1'b0, 1'b1, 8'h3C, 5'd1);
        check_eq("len1_second_q", 32'(q), 32'hA5);
        cycle("len1", 1'b0, 1'b1, 8'h7E, 5'd1);
        check_eq("len1_third_q", 32'(q), 32'h3C);

        // Sparse ce with L = 3; idle cycles must hold the outputs.
        do_reset();
        for (int i = 0; i < 60; i++)
            cycle("gaps", 1'b0, ($urandom_range(0, 99) < 40), 8'($urandom), 5'd3);

        // Reset with ce high mid-run, then a fresh run with L = 2.
        do_reset();
        for (int i = 1; i <= 20; i++) cycle("run8", 1'b0, 1'b1, 8'(8'h40 + i), 5'd8);
        cycle("midrst", 1'b1, 1'b1, 8'hEE, 5'd8);
        check_eq("midrst_valid", 32'(valid), 32'h0);
        for (int i = 1; i <= 6; i++) cycle("run2", 1'b0, 1'b1, 8'(8'h90 + i), 5'd2);

        // line_len changes after sample 2 are ignored.
        do_reset();
        for (int i = 1; i <= 12; i++)
            cycle("latch", 1'b0, 1'b1, 8'(8'h20 + i), (i <= 2) ? 5'd4 : 5'd9);

        // line_len = 0 selects the full depth; run across several wraps.
        do_reset();
        for (int i = 1; i <= 70; i++) cycle("len0", 1'b0, 1'b1, 8'(i * 3), 5'd0);

        // Oversize request also clamps to the full depth.
        do_reset();
        for (int i = 1; i <= 20; i++) cycle("len20", 1'b0, 1'b1, 8'(8'hC0 + i), 5'd20);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/median_line_delay.md
# median_line_delay

Single-clock circular-buffer line delay for the median filter datapath. It delays a clock-enabled pixel stream by a run-time-selected number of accepted samples, one image line, so that the window stage sees vertically adjacent pixels. It complements the single-sample delay register: that register writes and re-emits immediately, while this block stores a full line in RAM and reads it back one line later. It also provides a `valid` flag so downstream logic can ignore the priming period.

## Interface

- `N`, default 8: pixel width in bits.
- `MAX_LEN`, default 1024: maximum line length and RAM depth in words.
- `AW`, default 10: pointer width, with `2**AW >= MAX_LEN`.

- `clk`, input, 1 bit: single clock. All logic is on the rising edge.
- `rst`, input, 1 bit: synchronous, active-high reset. It takes priority over `ce`.
- `ce`, input, 1 bit: sample enable. One sample is accepted per cycle in which `ce` is high.
- `line_len`, input, AW+1 bits: requested delay L. It is sampled only on the first accepted sample after reset.
- `d`, input, N bits: input pixel.
- `q`, output, N bits: delayed pixel, registered.
- `valid`, output, 1 bit: `q` holds real delayed data, registered.

## Operation

- **Storage.** A MAX_LEN x N RAM, inferable as block or distributed RAM, with read-before-write on the same address.
- **Pointer.** `ptr` advances 0 → L-1 and wraps to 0. It only advances on accepted samples.
- **Latched length.**
  - L = `line_len` at the first accepted sample after reset.
  - If `line_len` is 0 or greater than MAX_LEN, L = MAX_LEN.
  - Changes to `line_len` outside IDLE are ignored until the next reset.
- **Fill counter.** Counts accepted samples and saturates at L.
- **State machine.**
  - IDLE: entered on reset. Waits for `ce`. On `ce`, latches L, writes the sample, and goes to FILL. If L = 1, it goes directly to RUN.
  - FILL: accepted samples 1..L. Writes `d` to `mem[ptr]`. `q` is forced to 0 and `valid` to 0. On the L-th accepted sample it goes to RUN.
  - RUN: each accepted sample reads `mem[ptr]` into `q`, writes `d` to `mem[ptr]`, and sets `valid` = 1. It stays in RUN until reset.
- **Transfer function.** Number accepted samples k = 1, 2, … from reset. After the edge accepting sample k:
  - For k > L: `q` = d(k-L), `valid` = 1.
  - For k ≤ L: `q` = 0, `valid` = 0.
- **Edge cases.**
  - **`ce` low:** `ptr`, counter, state, `q`, `valid` and RAM all hold.
  - **Reset mid-operation:** On the edge with `rst` high, return to IDLE with `q` = 0, `valid` = 0, `ptr` = 0 and counter = 0. This applies even if `ce` is high on that edge. RAM is not cleared. Stale RAM contents are never visible, because FILL masks the output.
  - **L = 1:** Behaves as a one-sample registered delay: `q` = d(k-1) after sample k, with `valid` from k = 2.
  - **L = MAX_LEN:** The pointer uses the full RAM, wraps MAX_LEN-1 → 0, and has no off-by-one at the wrap.

## Timing

- **Reset values:** `q` = 0, `valid` = 0, state = IDLE, `ptr` = 0, counter = 0.
- **Output registering:** `q` and `valid` update only on edges with `ce` high (or reset). There is no combinational path from `d` or `ce` to the outputs.
- **Latency:**
  - Sample k appears on `q` after the edge accepting sample k+L.
  - With continuous `ce`, that is L clock cycles after `d` is presented.
- **Throughput:** One sample per cycle. No back-pressure.
- **RAM:** Single-port style, one read and one write to the same address per accepted sample. The read returns the old data.

## Test plan

- **Ramp, L = 4:** Reset, `line_len` = 4, continuous `ce`, `d` = 1, 2, 3, …
  - `valid` rises after the 5th sample with `q` = 1.
  - After sample 20, `q` = 16.
  - `q` = 0 throughout the fill.
- **L = 1:** `d` = 0xA5, 0x3C, 0x7E.
  - After the 2nd sample: `q` = 0xA5, `valid` = 1.
  - After the 3rd sample: `q` = 0x3C.
- **`ce` gaps, L = 3:** Random `ce` duty around 40%.
  - `q` matches a scoreboard of accepted samples delayed by 3.
  - Outputs hold stable on cycles with `ce` low.
- **Reset mid-run, L = 8:** Assert `rst` with `ce` high after 20 samples.
  - Next cycle: `q` = 0, `valid` = 0.
  - The new run (`line_len` = 2) outputs the first new sample after its 3rd sample, with no stale data.
- **Length latch:** Change `line_len` from 4 to 9 after sample 2. The delay stays 4.
- **`line_len` = 0 and MAX_LEN = 16:** The delay is 16.
  - `valid` rises after sample 17.
  - Correct data continues across at least 3 pointer wraps.
